// File: rtl/mips_pkg.sv
// Shared encodings for the ID/EX stage: ALU command codes, ALUOp classes,
// and the R-type funct / I-type opcode values the ALU-control decode recognises.
package mips_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_RTYPE = 2'd2,
        ALUOP_ITYPE = 2'd3
    } alu_op_e;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_OR  = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_XOR = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0110;
    localparam logic [3:0] CMD_SLT = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRL = 4'b1001;
    localparam logic [3:0] CMD_NOR = 4'b1100;
    localparam logic [3:0] CMD_EQ  = 4'b1111;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU-control decode: ALUOp class plus funct/opcode/branch -> ALU command.
// Unrecognised funct or opcode falls back to ADD and raises illegal_o.
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    input  logic [5:0] opcode_i,
    input  logic       branch_i,
    output logic [3:0] cmd_o,
    output logic       illegal_o
);

    always_comb begin
        cmd_o     = CMD_ADD;
        illegal_o = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: cmd_o = CMD_ADD;
            ALUOP_SUB: cmd_o = branch_i ? CMD_EQ : CMD_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  cmd_o = CMD_ADD;
                    FN_SUB:  cmd_o = CMD_SUB;
                    FN_AND:  cmd_o = CMD_AND;
                    FN_OR:   cmd_o = CMD_OR;
                    FN_XOR:  cmd_o = CMD_XOR;
                    FN_NOR:  cmd_o = CMD_NOR;
                    FN_SLT:  cmd_o = CMD_SLT;
                    FN_SLL:  cmd_o = CMD_SLL;
                    FN_SRL:  cmd_o = CMD_SRL;
                    default: illegal_o = 1'b1;
                endcase
            end
            default: begin
                case (opcode_i)
                    OP_ADDI: cmd_o = CMD_ADD;
                    OP_ANDI: cmd_o = CMD_AND;
                    OP_ORI:  cmd_o = CMD_OR;
                    OP_XORI: cmd_o = CMD_XOR;
                    OP_SLTI: cmd_o = CMD_SLT;
                    default: illegal_o = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode and ALU operand selection.
// Define ID_EX_FWD_EN to forward from EX/MEM and MEM/WB; otherwise operands come from registered reads only.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [1:0]    id_ALUOp,
    input  logic          id_ALUSrc,
    input  logic          id_RegDst,
    input  logic          id_RegWrite,
    input  logic          id_MemRead,
    input  logic          id_MemWrite,
    input  logic          id_MemtoReg,
    input  logic          id_branch,
    input  logic          exmem_RegWrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_alu_out,
    input  logic          memwb_RegWrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_wdata,
    output logic [DW-1:0] input1,
    output logic [DW-1:0] input2,
    output logic [3:0]    ex_cmd,
    output logic [1:0]    ALUOp,
    output logic          branchD,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_valid,
    output logic          ex_RegWrite,
    output logic          ex_MemRead,
    output logic          ex_MemWrite,
    output logic          ex_MemtoReg,
    output logic          ex_illegal
);

    logic [3:0] dec_cmd;
    logic       dec_illegal;

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op_i (id_ALUOp),
        .funct_i  (id_funct),
        .opcode_i (id_opcode),
        .branch_i (id_branch),
        .cmd_o    (dec_cmd),
        .illegal_o(dec_illegal)
    );

    logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [1:0]    aluop_q, aluop_d;
    logic          valid_q, valid_d, illegal_q, illegal_d, branch_q, branch_d, alusrc_q, alusrc_d;
    logic          regwrite_q, regwrite_d, memread_q, memread_d;
    logic          memwrite_q, memwrite_d, memtoreg_q, memtoreg_d;

    // flush wins over stall; a load with id_valid=0 is also a bubble
    always_comb begin
        rs_data_d  = rs_data_q;  rt_data_d  = rt_data_q;  imm_d      = imm_q;
        rs_d       = rs_q;       rt_d       = rt_q;       dest_d     = dest_q;
        cmd_d      = cmd_q;      aluop_d    = aluop_q;    valid_d    = valid_q;
        illegal_d  = illegal_q;  branch_d   = branch_q;   alusrc_d   = alusrc_q;
        regwrite_d = regwrite_q; memread_d  = memread_q;  memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        if (flush || !stall) begin
            if (flush || !id_valid) begin
                rs_data_d  = '0;    rt_data_d  = '0;    imm_d      = '0;
                rs_d       = '0;    rt_d       = '0;    dest_d     = '0;
                cmd_d      = CMD_ADD;
                aluop_d    = '0;    valid_d    = 1'b0;  illegal_d  = 1'b0;
                branch_d   = 1'b0;  alusrc_d   = 1'b0;  regwrite_d = 1'b0;
                memread_d  = 1'b0;  memwrite_d = 1'b0;  memtoreg_d = 1'b0;
            end else begin
                rs_data_d  = id_rs_data;  rt_data_d  = id_rt_data;  imm_d      = id_imm;
                rs_d       = id_rs;       rt_d       = id_rt;
                dest_d     = id_RegDst ? id_rd : id_rt;
                cmd_d      = dec_cmd;     aluop_d    = id_ALUOp;    valid_d    = 1'b1;
                illegal_d  = dec_illegal; branch_d   = id_branch;   alusrc_d   = id_ALUSrc;
                regwrite_d = id_RegWrite; memread_d  = id_MemRead;  memwrite_d = id_MemWrite;
                memtoreg_d = id_MemtoReg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_data_q  <= '0;    rt_data_q  <= '0;    imm_q      <= '0;
            rs_q       <= '0;    rt_q       <= '0;    dest_q     <= '0;
            cmd_q      <= CMD_ADD;
            aluop_q    <= '0;    valid_q    <= 1'b0;  illegal_q  <= 1'b0;
            branch_q   <= 1'b0;  alusrc_q   <= 1'b0;  regwrite_q <= 1'b0;
            memread_q  <= 1'b0;  memwrite_q <= 1'b0;  memtoreg_q <= 1'b0;
        end else begin
            rs_data_q  <= rs_data_d;  rt_data_q  <= rt_data_d;  imm_q      <= imm_d;
            rs_q       <= rs_d;       rt_q       <= rt_d;       dest_q     <= dest_d;
            cmd_q      <= cmd_d;      aluop_q    <= aluop_d;    valid_q    <= valid_d;
            illegal_q  <= illegal_d;  branch_q   <= branch_d;   alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d; memread_q  <= memread_d;  memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
        end
    end

    logic [DW-1:0] fwd_rs, fwd_rt;

`ifdef ID_EX_FWD_EN
    // EX/MEM is the younger producer, so it beats MEM/WB; r0 is never forwarded
    always_comb begin
        fwd_rs = rs_data_q;
        if (exmem_RegWrite && exmem_rd != '0 && exmem_rd == rs_q)
            fwd_rs = exmem_alu_out;
        else if (memwb_RegWrite && memwb_rd != '0 && memwb_rd == rs_q)
            fwd_rs = memwb_wdata;
        fwd_rt = rt_data_q;
        if (exmem_RegWrite && exmem_rd != '0 && exmem_rd == rt_q)
            fwd_rt = exmem_alu_out;
        else if (memwb_RegWrite && memwb_rd != '0 && memwb_rd == rt_q)
            fwd_rt = memwb_wdata;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_RegWrite, exmem_rd, exmem_alu_out,
                          memwb_RegWrite, memwb_rd, memwb_wdata, rs_q, rt_q};
    assign fwd_rs = rs_data_q;
    assign fwd_rt = rt_data_q;
`endif

    logic is_shift;
    assign is_shift = (cmd_q == CMD_SLL) || (cmd_q == CMD_SRL);

    // shifts operate on rt by the shamt field held in imm[10:6]
    assign input1        = is_shift ? fwd_rt : fwd_rs;
    assign input2        = is_shift ? {{(DW-5){1'b0}}, imm_q[10:6]} : (alusrc_q ? imm_q : fwd_rt);
    assign ex_store_data = fwd_rt;
    assign ex_cmd        = cmd_q;
    assign ALUOp         = aluop_q;
    assign branchD       = branch_q;
    assign ex_dest       = dest_q;
    assign ex_valid      = valid_q;
    assign ex_RegWrite   = regwrite_q;
    assign ex_MemRead    = memread_q;
    assign ex_MemWrite   = memwrite_q;
    assign ex_MemtoReg   = memtoreg_q;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, decode classes, forwarding, stall/flush, illegal codes.
// Forwarding expectations follow whether ID_EX_FWD_EN is defined for the build.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst, stall, flush, id_valid;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [5:0]    id_opcode, id_funct;
    logic [1:0]    id_ALUOp;
    logic          id_ALUSrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_branch;
    logic          exmem_RegWrite, memwb_RegWrite;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [DW-1:0] exmem_alu_out, memwb_wdata;
    logic [DW-1:0] input1, input2, ex_store_data;
    logic [3:0]    ex_cmd;
    logic [1:0]    ALUOp;
    logic          branchD;
    logic [RW-1:0] ex_dest;
    logic          ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_ALUOp(id_ALUOp),
        .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg),
        .id_branch(id_branch),
        .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
        .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .input1(input1), .input2(input2), .ex_cmd(ex_cmd), .ALUOp(ALUOp), .branchD(branchD),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_illegal(ex_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_opcode = '0; id_funct = '0; id_ALUOp = '0;
        id_ALUSrc = 0; id_RegDst = 0; id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0;
        id_MemtoReg = 0; id_branch = 0;
        exmem_RegWrite = 0; exmem_rd = '0; exmem_alu_out = '0;
        memwb_RegWrite = 0; memwb_rd = '0; memwb_wdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        id_valid = 1; id_ALUOp = 2'd2; id_funct = 6'h22; id_rs_data = 32'd55; id_RegWrite = 1;
        rst = 1;
        tick(); tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ex_valid); end
        n_cmp++; if (ex_cmd !== 4'b0010) begin n_fail++; $display("FAIL reset_cmd got %b want 0010", ex_cmd); end
        n_cmp++; if (input1 !== 32'd0) begin n_fail++; $display("FAIL reset_in1 got %0d want 0", input1); end
        n_cmp++; if (input2 !== 32'd0) begin n_fail++; $display("FAIL reset_in2 got %0d want 0", input2); end
        n_cmp++; if ({ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, branchD, ex_illegal} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 000000",
                               {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, branchD, ex_illegal});
        end
        rst = 0;
        clear_inputs();
        tick();
    endtask

    task automatic test_rtype();
        clear_inputs();
        id_valid = 1; id_ALUOp = 2'd2; id_funct = 6'h22; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
        id_rs_data = 32'd88; id_rt_data = 32'd88; id_RegDst = 1; id_RegWrite = 1;
        tick();
        n_cmp++; if (ex_cmd !== 4'b0110) begin n_fail++; $display("FAIL sub_cmd got %b want 0110", ex_cmd); end
        n_cmp++; if (input1 !== 32'd88) begin n_fail++; $display("FAIL sub_in1 got %0d want 88", input1); end
        n_cmp++; if (input2 !== 32'd88) begin n_fail++; $display("FAIL sub_in2 got %0d want 88", input2); end
        n_cmp++; if (ex_dest !== 5'd3) begin n_fail++; $display("FAIL sub_dest got %0d want 3", ex_dest); end
        n_cmp++; if ({ex_valid, ex_RegWrite, ALUOp} !== 4'b1110) begin
            n_fail++; $display("FAIL sub_ctrl got %b want 1110", {ex_valid, ex_RegWrite, ALUOp});
        end
    endtask

    // back-to-back loads: SLL then ORI on consecutive edges
    task automatic test_back_to_back();
        clear_inputs();
        id_valid = 1; id_ALUOp = 2'd2; id_funct = 6'h00; id_rt = 5'd2; id_rd = 5'd9;
        id_rs_data = 32'd77; id_rt_data = 32'h11; id_imm = 32'h100; id_RegDst = 1; id_RegWrite = 1;
        tick();
        n_cmp++; if (ex_cmd !== 4'b1000) begin n_fail++; $display("FAIL sll_cmd got %b want 1000", ex_cmd); end
        n_cmp++; if (input1 !== 32'h11) begin n_fail++; $display("FAIL sll_in1 got %h want 11", input1); end
        n_cmp++; if (input2 !== 32'd4) begin n_fail++; $display("FAIL sll_in2 got %0d want 4", input2); end
        id_ALUOp = 2'd3; id_opcode = 6'h0D; id_funct = 6'h3F; id_rs = 5'd6; id_rt = 5'd7;
        id_rs_data = 32'hF0; id_rt_data = 32'd1; id_imm = 32'h55; id_ALUSrc = 1; id_RegDst = 0;
        tick();
        n_cmp++; if (ex_cmd !== 4'b0001) begin n_fail++; $display("FAIL ori_cmd got %b want 0001", ex_cmd); end
        n_cmp++; if (input1 !== 32'hF0) begin n_fail++; $display("FAIL ori_in1 got %h want f0", input1); end
        n_cmp++; if (input2 !== 32'h55) begin n_fail++; $display("FAIL ori_in2 got %h want 55", input2); end
        n_cmp++; if (ex_dest !== 5'd7) begin n_fail++; $display("FAIL ori_dest got %0d want 7", ex_dest); end
        n_cmp++; if (ex_illegal !== 1'b0) begin n_fail++; $display("FAIL ori_illegal got %b want 0", ex_illegal); end
    endtask

    task automatic test_branch();
        clear_inputs();
        id_valid = 1; id_ALUOp = 2'd1; id_branch = 1; id_rs = 5'd1; id_rt = 5'd2;
        id_rs_data = 32'd88; id_rt_data = 32'd88;
        tick();
        n_cmp++; if (ex_cmd !== 4'b1111) begin n_fail++; $display("FAIL beq_cmd got %b want 1111", ex_cmd); end
        n_cmp++; if (branchD !== 1'b1) begin n_fail++; $display("FAIL beq_branchD got %b want 1", branchD); end
        n_cmp++; if (ex_RegWrite !== 1'b0) begin n_fail++; $display("FAIL beq_regwrite got %b want 0", ex_RegWrite); end
        id_branch = 0;
        tick();
        n_cmp++; if (ex_cmd !== 4'b0110) begin n_fail++; $display("FAIL aluop1_sub got %b want 0110", ex_cmd); end
    endtask

    task automatic test_forwarding();
        logic [DW-1:0] e1, e2, e3, e4, e5;
`ifdef ID_EX_FWD_EN
        e1 = 32'd7; e2 = 32'd9; e3 = 32'd100; e4 = 32'd9; e5 = 32'd200;
`else
        e1 = 32'd100; e2 = 32'd100; e3 = 32'd100; e4 = 32'd200; e5 = 32'd200;
`endif
        clear_inputs();
        id_valid = 1; id_ALUOp = 2'd0; id_rs = 5'd5; id_rt = 5'd6;
        id_rs_data = 32'd100; id_rt_data = 32'd200;
        tick();
        exmem_RegWrite = 1; exmem_rd = 5'd5; exmem_alu_out = 32'd7;
        memwb_RegWrite = 1; memwb_rd = 5'd5; memwb_wdata = 32'd9;
        #1;
        n_cmp++; if (input1 !== e1) begin n_fail++; $display("FAIL fwd_exmem got %0d want %0d", input1, e1); end
        n_cmp++; if (input2 !== 32'd200) begin n_fail++; $display("FAIL fwd_rt_nomatch got %0d want 200", input2); end
        exmem_rd = 5'd0;
        #1;
        n_cmp++; if (input1 !== e2) begin n_fail++; $display("FAIL fwd_memwb got %0d want %0d", input1, e2); end
        memwb_rd = 5'd6;
        #1;
        n_cmp++; if (input1 !== e3) begin n_fail++; $display("FAIL fwd_none got %0d want %0d", input1, e3); end
        n_cmp++; if (ex_store_data !== e4) begin n_fail++; $display("FAIL fwd_store got %0d want %0d", ex_store_data, e4); end
        memwb_RegWrite = 0;
        #1;
        n_cmp++; if (input2 !== e5) begin n_fail++; $display("FAIL fwd_nowrite got %0d want %0d", input2, e5); end
        clear_inputs();
        id_valid = 1; id_ALUOp = 2'd0; id_rs = 5'd0; id_rs_data = 32'd0;
        exmem_RegWrite = 1; exmem_rd = 5'd0; exmem_alu_out = 32'd7;
        tick();
        n_cmp++; if (input1 !== 32'd0) begin n_fail++; $display("FAIL fwd_r0 got %0d want 0", input1); end
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        id_valid = 1; id_ALUOp = 2'd0; id_ALUSrc = 1; id_rs = 5'd3; id_rt = 5'd4;
        id_rs_data = 32'd30; id_imm = 32'd12; id_RegWrite = 1;
        tick();
        n_cmp++; if (input1 !== 32'd30 || input2 !== 32'd12) begin
            n_fail++; $display("FAIL addi_ops got %0d,%0d want 30,12", input1, input2);
        end
        stall = 1; id_ALUOp = 2'd2; id_funct = 6'h24; id_ALUSrc = 0; id_rs_data = 32'd1;
        id_rt_data = 32'd2; id_rt = 5'd8; id_RegWrite = 0; id_MemWrite = 1;
        tick(); tick();
        n_cmp++; if (ex_cmd !== 4'b0010) begin n_fail++; $display("FAIL stall_cmd got %b want 0010", ex_cmd); end
        n_cmp++; if (input1 !== 32'd30 || input2 !== 32'd12) begin
            n_fail++; $display("FAIL stall_ops got %0d,%0d want 30,12", input1, input2);
        end
        n_cmp++; if ({ex_valid, ex_RegWrite, ex_MemWrite} !== 3'b110 || ex_dest !== 5'd4) begin
            n_fail++; $display("FAIL stall_ctrl got %b dest %0d want 110 dest 4",
                               {ex_valid, ex_RegWrite, ex_MemWrite}, ex_dest);
        end
        flush = 1;
        tick();
        n_cmp++; if ({ex_valid, ex_RegWrite, ex_MemWrite} !== 3'b000) begin
            n_fail++; $display("FAIL flush_ctrl got %b want 000", {ex_valid, ex_RegWrite, ex_MemWrite});
        end
        n_cmp++; if (ex_cmd !== 4'b0010 || input1 !== 32'd0) begin
            n_fail++; $display("FAIL flush_data got cmd %b in1 %0d want 0010,0", ex_cmd, input1);
        end
    endtask

    task automatic test_illegal();
        clear_inputs();
        id_valid = 1; id_ALUOp = 2'd2; id_funct = 6'h3F; id_RegWrite = 1;
        tick();
        n_cmp++; if (ex_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_funct got %b want 1", ex_illegal); end
        n_cmp++; if (ex_cmd !== 4'b0010) begin n_fail++; $display("FAIL ill_cmd got %b want 0010", ex_cmd); end
        id_valid = 0;
        tick();
        n_cmp++; if (ex_illegal !== 1'b0 || ex_valid !== 1'b0 || ex_RegWrite !== 1'b0) begin
            n_fail++; $display("FAIL ill_invalid got ill %b valid %b rw %b want 0 0 0", ex_illegal, ex_valid, ex_RegWrite);
        end
        id_valid = 1; id_ALUOp = 2'd3; id_opcode = 6'h23;
        tick();
        n_cmp++; if (ex_illegal !== 1'b1 || ex_cmd !== 4'b0010) begin
            n_fail++; $display("FAIL ill_opcode got ill %b cmd %b want 1 0010", ex_illegal, ex_cmd);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_rtype();
        test_back_to_back();
        test_branch();
        test_forwarding();
        test_stall_flush();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
